// File: rtl/spi_slave.sv
// SPI peripheral with SCLK, CS_n and MOSI oversampled in the i_clk domain.
// Byte-parallel side uses a DV/Ready handshake; MSB first, 8-bit words.
module spi_slave #(
    parameter int         SPI_MODE  = 3,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic       i_SPI_clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En
);

    localparam logic CPOL = SPI_MODE[1];
    localparam logic CPHA = SPI_MODE[0];

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t     state;

    logic       sclk_meta, sclk_sync, sclk_d;
    logic       cs_meta, cs_sync, cs_d;
    logic       mosi_meta, mosi_sync;

    logic [2:0] rx_cnt;
    logic [6:0] rx_shift;
    logic       rx_done;
    logic [2:0] tx_cnt;
    logic [6:0] tx_shift;
    logic [7:0] hold_byte;

    logic       leading_edge, trailing_edge;
    logic       sample_edge, shift_edge;
    logic       cs_fall, load_point;
    logic [7:0] load_byte;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_meta <= CPOL;
            sclk_sync <= CPOL;
            sclk_d    <= CPOL;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_d      <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sclk_meta <= i_SPI_clk;
            sclk_sync <= sclk_meta;
            sclk_d    <= sclk_sync;
            cs_meta   <= i_SPI_CS_n;
            cs_sync   <= cs_meta;
            cs_d      <= cs_sync;
            mosi_meta <= i_SPI_MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    assign leading_edge  = (sclk_d == CPOL) && (sclk_sync != CPOL);
    assign trailing_edge = (sclk_d != CPOL) && (sclk_sync == CPOL);
    assign sample_edge   = (CPHA ? trailing_edge : leading_edge) && !cs_sync && (state == ACTIVE);
    assign shift_edge    = (CPHA ? leading_edge : trailing_edge) && !cs_sync && (state == ACTIVE);
    assign cs_fall       = cs_d && !cs_sync;

    // CPHA=0 must present bit 7 before the first sample edge, so CS_n fall is also a load point.
    assign load_point = (shift_edge && (tx_cnt == 3'd0)) ||
                        (!CPHA && (state == IDLE) && cs_fall);
    assign load_byte  = o_TX_Ready ? IDLE_BYTE : hold_byte;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            o_TX_Ready    <= 1'b1;
            o_RX_DV       <= 1'b0;
            o_RX_Byte     <= 8'h00;
            o_SPI_MISO    <= 1'b1;
            o_SPI_MISO_En <= 1'b0;
            rx_cnt        <= 3'd0;
            rx_shift      <= 7'd0;
            rx_done       <= 1'b0;
            tx_cnt        <= 3'd0;
            tx_shift      <= 7'd0;
            hold_byte     <= 8'h00;
        end else begin
            rx_done <= 1'b0;
            o_RX_DV <= rx_done;

            // A strobe coincident with a load point fills the register for the next load point.
            if (o_TX_Ready && i_TX_DV) begin
                hold_byte  <= i_TX_Byte;
                o_TX_Ready <= 1'b0;
            end else if (load_point) begin
                o_TX_Ready <= 1'b1;
            end

            case (state)
                IDLE: begin
                    o_SPI_MISO <= 1'b1;
                    if (cs_fall) begin
                        state         <= ACTIVE;
                        o_SPI_MISO_En <= 1'b1;
                        if (!CPHA) begin
                            o_SPI_MISO <= load_byte[7];
                            tx_shift   <= load_byte[6:0];
                            tx_cnt     <= 3'd1;
                        end
                    end
                end

                ACTIVE: begin
                    if (cs_sync) begin
                        state         <= IDLE;
                        o_SPI_MISO_En <= 1'b0;
                        o_SPI_MISO    <= 1'b1;
                        rx_cnt        <= 3'd0;
                        rx_shift      <= 7'd0;
                        tx_cnt        <= 3'd0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= {rx_shift[5:0], mosi_sync};
                            rx_cnt   <= rx_cnt + 3'd1;
                            if (rx_cnt == 3'd7) begin
                                o_RX_Byte <= {rx_shift, mosi_sync};
                                rx_done   <= 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            if (tx_cnt == 3'd0) begin
                                o_SPI_MISO <= load_byte[7];
                                tx_shift   <= load_byte[6:0];
                            end else begin
                                o_SPI_MISO <= tx_shift[6];
                                tx_shift   <= {tx_shift[5:0], 1'b0};
                            end
                            tx_cnt <= tx_cnt + 3'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
